// File: rtl/gcm_pkg.sv
// rtl/gcm_pkg.sv - shared GCM block constants and counter-generator FSM states
package gcm_pkg;
  localparam int          BLOCK_W   = 128;
  localparam int          IV_W      = 96;
  localparam logic [31:0] J0_LOW    = 32'h1;
  localparam logic [31:0] CTR_START = 32'h2;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/ctr_lane_add.sv
// rtl/ctr_lane_add.sv - builds LANES consecutive counter blocks from a base and fixed prefix
module ctr_lane_add
  import gcm_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CTR_W = 32
) (
  input  logic [CTR_W-1:0]         base,
  input  logic [BLOCK_W-CTR_W-1:0] prefix,
  output logic [LANES*BLOCK_W-1:0] blocks
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign blocks[i*BLOCK_W +: BLOCK_W] = {prefix, base + CTR_W'(i)};
  end
endmodule

// File: rtl/ctr_gen_multi.sv
// rtl/ctr_gen_multi.sv - multi-lane AES-GCM counter-block generator with J0 export and length limit
module ctr_gen_multi
  import gcm_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CTR_W = 32,
  parameter int NB_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_iv,
  input  logic [IV_W-1:0]          iv96,
  input  logic [NB_W-1:0]          num_blocks,
  output logic [BLOCK_W-1:0]       j0,
  output logic                     j0_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*BLOCK_W-1:0] ctr_blocks,
  output logic [LANES-1:0]         lane_mask,
  output logic                     last,
  output logic                     done,
  output logic                     len_err
);
  localparam int          PFX_W      = BLOCK_W - CTR_W;
  localparam logic [63:0] MAX_BLOCKS = (64'd1 << CTR_W) - 64'd2;

  state_t                     state;
  logic [CTR_W-1:0]           base_q;
  logic [NB_W-1:0]            rem_q;
  logic [PFX_W-1:0]           prefix_q;

  logic                       too_long;
  logic                       accept;
  logic [CTR_W-1:0]           nxt_base;
  logic [NB_W-1:0]            nxt_rem;
  logic [PFX_W-1:0]           nxt_prefix;
  logic [LANES-1:0]           nxt_mask;
  logic                       nxt_last;
  logic [LANES*BLOCK_W-1:0]   nxt_blocks;

  assign too_long = 64'(num_blocks) > MAX_BLOCKS;
  assign accept   = out_valid && out_ready;

  // The next group is either the first group of a new load or the successor of the current one.
  always_comb begin
    nxt_base   = base_q + CTR_W'(LANES);
    nxt_rem    = rem_q - NB_W'(LANES);
    nxt_prefix = prefix_q;
    if (load_iv) begin
      nxt_base   = CTR_W'(CTR_START);
      nxt_rem    = num_blocks;
      nxt_prefix = PFX_W'({iv96, 32'h0} >> CTR_W);
    end
    nxt_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      nxt_mask[i] = NB_W'(i) < nxt_rem;
    end
    nxt_last = nxt_rem <= NB_W'(LANES);
  end

  ctr_lane_add #(
    .LANES (LANES),
    .CTR_W (CTR_W)
  ) u_lane_add (
    .base   (nxt_base),
    .prefix (nxt_prefix),
    .blocks (nxt_blocks)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_q     <= '0;
      rem_q      <= '0;
      prefix_q   <= '0;
      j0         <= '0;
      j0_valid   <= 1'b0;
      out_valid  <= 1'b0;
      ctr_blocks <= '0;
      lane_mask  <= '0;
      last       <= 1'b0;
      done       <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_iv) begin
        // A load in any state restarts; it wins over a same-cycle accept.
        out_valid <= 1'b0;
        lane_mask <= '0;
        last      <= 1'b0;
        state     <= IDLE;
        if (too_long) begin
          len_err  <= 1'b1;
          j0_valid <= 1'b0;
        end else begin
          len_err  <= 1'b0;
          j0       <= {iv96, J0_LOW};
          j0_valid <= 1'b1;
          prefix_q <= nxt_prefix;
          if (num_blocks == '0) begin
            done <= 1'b1;
          end else begin
            base_q     <= nxt_base;
            rem_q      <= nxt_rem;
            ctr_blocks <= nxt_blocks;
            lane_mask  <= nxt_mask;
            last       <= nxt_last;
            out_valid  <= 1'b1;
            state      <= RUN;
          end
        end
      end else begin
        case (state)
          RUN: begin
            if (accept) begin
              if (last) begin
                out_valid <= 1'b0;
                lane_mask <= '0;
                last      <= 1'b0;
                done      <= 1'b1;
                state     <= FIN;
              end else begin
                base_q     <= nxt_base;
                rem_q      <= nxt_rem;
                ctr_blocks <= nxt_blocks;
                lane_mask  <= nxt_mask;
                last       <= nxt_last;
              end
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ctr_gen_multi.sv
// tb/tb_ctr_gen_multi.sv - directed self-checking bench for ctr_gen_multi
module tb_ctr_gen_multi;
  localparam logic [95:0] IV_A = 96'hCAFEBABE_FACEDBAD_DECAF888;
  localparam logic [95:0] IV_B = 96'h01234567_89ABCDEF_0F1E2D3C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_iv, load8;
  logic [95:0]  iv96;
  logic [31:0]  num_blocks, nb8;
  logic         out_ready, ready8;
  logic [127:0] j0, j0_8;
  logic         j0_valid, j0_valid8;
  logic         out_valid, out_valid8;
  logic [511:0] ctr_blocks, ctr_blocks8;
  logic [3:0]   lane_mask, lane_mask8;
  logic         last, last8, done, done8, len_err, len_err8;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ctr_gen_multi #(.LANES(4), .CTR_W(32), .NB_W(32)) u_dut (
    .clk (clk), .rst_n (rst_n), .load_iv (load_iv), .iv96 (iv96),
    .num_blocks (num_blocks), .j0 (j0), .j0_valid (j0_valid),
    .out_valid (out_valid), .out_ready (out_ready), .ctr_blocks (ctr_blocks),
    .lane_mask (lane_mask), .last (last), .done (done), .len_err (len_err)
  );

  ctr_gen_multi #(.LANES(4), .CTR_W(8), .NB_W(32)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .load_iv (load8), .iv96 (iv96),
    .num_blocks (nb8), .j0 (j0_8), .j0_valid (j0_valid8),
    .out_valid (out_valid8), .out_ready (ready8), .ctr_blocks (ctr_blocks8),
    .lane_mask (lane_mask8), .last (last8), .done (done8), .len_err (len_err8)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check_group(input string tag, input logic [95:0] iv, input logic [31:0] b,
                             input logic [3:0] m, input logic l);
    check({tag, "_valid"}, 128'(out_valid), 128'd1);
    check({tag, "_mask"}, 128'(lane_mask), 128'(m));
    check({tag, "_last"}, 128'(last), 128'(l));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_lane%0d", tag, i), ctr_blocks[128*i +: 128], {iv, b + 32'(i)});
    end
  endtask

  logic [23:0] pat;
  int          g, dn;
  logic        seen, found;

  initial begin
    rst_n = 1'b0; load_iv = 1'b0; load8 = 1'b0; iv96 = '0; num_blocks = '0; nb8 = '0;
    out_ready = 1'b0; ready8 = 1'b0;
    repeat (2) tick;
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_blocks", 128'(|ctr_blocks), 128'd0);
    check("rst_mask", 128'(lane_mask), 128'd0);
    check("rst_last", 128'(last), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_j0", j0, 128'd0);
    check("rst_j0v", 128'(j0_valid), 128'd0);
    check("rst_lenerr", 128'(len_err), 128'd0);
    rst_n = 1'b1;
    tick;

    // Basic run: 10 blocks, consumer always ready
    iv96 = IV_A; num_blocks = 32'd10; out_ready = 1'b1; load_iv = 1'b1;
    tick; load_iv = 1'b0;
    check("t1_j0", j0, {IV_A, 32'h1});
    check("t1_j0v", 128'(j0_valid), 128'd1);
    check_group("t1_g0", IV_A, 32'd2, 4'hF, 1'b0); tick;
    check_group("t1_g1", IV_A, 32'd6, 4'hF, 1'b0); tick;
    check_group("t1_g2", IV_A, 32'd10, 4'h3, 1'b1); tick;
    check("t1_end_valid", 128'(out_valid), 128'd0);
    check("t1_end_mask", 128'(lane_mask), 128'd0);
    check("t1_done", 128'(done), 128'd1);
    tick;
    check("t1_done_off", 128'(done), 128'd0);

    // Backpressure: 8 blocks, irregular ready
    pat = 24'h0000B2;
    out_ready = 1'b0; num_blocks = 32'd8; load_iv = 1'b1;
    tick; load_iv = 1'b0;
    g = 0; dn = 0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick;
      if (done) dn++;
      if (out_valid) begin
        check("t2_hold_l0", ctr_blocks[127:0], {IV_A, 32'(2 + 4 * g)});
        check("t2_hold_l3", ctr_blocks[511:384], {IV_A, 32'(5 + 4 * g)});
      end
      out_ready = pat[c];
      if (out_valid && out_ready) g++;
    end
    out_ready = 1'b0;
    check("t2_groups", 128'(g), 128'd2);
    check("t2_done_cnt", 128'(dn), 128'd1);

    // Limit rejection, then the largest legal length, then a zero-length load
    num_blocks = 32'hFFFF_FFFF; load_iv = 1'b1;
    tick; load_iv = 1'b0;
    check("t3_lenerr", 128'(len_err), 128'd1);
    check("t3_j0v", 128'(j0_valid), 128'd0);
    seen = out_valid;
    repeat (4) begin tick; seen = seen | out_valid; end
    check("t3_no_valid", 128'(seen), 128'd0);
    num_blocks = 32'hFFFF_FFFE; load_iv = 1'b1;
    tick; load_iv = 1'b0;
    check("t3_max_lenerr", 128'(len_err), 128'd0);
    check_group("t3_max", IV_A, 32'd2, 4'hF, 1'b0);
    num_blocks = 32'd0; load_iv = 1'b1;
    tick; load_iv = 1'b0;
    check("t3_zero_done", 128'(done), 128'd1);
    check("t3_zero_valid", 128'(out_valid), 128'd0);
    check("t3_zero_j0v", 128'(j0_valid), 128'd1);
    tick;
    check("t3_zero_done_off", 128'(done), 128'd0);

    // Abort: reload with a new IV while a group is pending and ready is high
    iv96 = IV_A; num_blocks = 32'd10; out_ready = 1'b0; load_iv = 1'b1;
    tick; load_iv = 1'b0;
    check_group("t4_old", IV_A, 32'd2, 4'hF, 1'b0);
    iv96 = IV_B; num_blocks = 32'd5; out_ready = 1'b1; load_iv = 1'b1;
    tick; load_iv = 1'b0;
    check("t4_no_done", 128'(done), 128'd0);
    check_group("t4_b0", IV_B, 32'd2, 4'hF, 1'b0); tick;
    check_group("t4_b1", IV_B, 32'd6, 4'h1, 1'b1); tick;
    check("t4_done", 128'(done), 128'd1);
    check("t4_j0", j0, {IV_B, 32'h1});
    out_ready = 1'b0;
    tick;

    // Wrap with an 8-bit counter: 254 blocks is the limit, final counter 8'hFF
    nb8 = 32'd254; ready8 = 1'b1; load8 = 1'b1;
    tick; load8 = 1'b0;
    g = 0; found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) tick;
      if (out_valid8 && last8) begin
        found = 1'b1;
        break;
      end
      if (out_valid8) g++;
    end
    check("t5_found_last", 128'(found), 128'd1);
    check("t5_groups", 128'(g), 128'd63);
    check("t5_mask", 128'(lane_mask8), 128'h3);
    check("t5_lane0", ctr_blocks8[127:0], {IV_B, 24'h0, 8'hFE});
    check("t5_lane1", ctr_blocks8[255:128], {IV_B, 24'h0, 8'hFF});
    check("t5_lenerr", 128'(len_err8), 128'd0);
    tick;
    check("t5_done", 128'(done8), 128'd1);
    nb8 = 32'd255; load8 = 1'b1;
    tick; load8 = 1'b0;
    check("t5_rej_lenerr", 128'(len_err8), 128'd1);
    check("t5_rej_valid", 128'(out_valid8), 128'd0);
    ready8 = 1'b0;

    // Asynchronous reset in the middle of a run
    iv96 = IV_A; num_blocks = 32'd10; load_iv = 1'b1;
    tick; load_iv = 1'b0;
    check("t6_pre_valid", 128'(out_valid), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 128'(out_valid), 128'd0);
    check("t6_blocks", 128'(|ctr_blocks), 128'd0);
    check("t6_mask", 128'(lane_mask), 128'd0);
    check("t6_j0", j0, 128'd0);
    check("t6_j0v", 128'(j0_valid), 128'd0);
    tick;
    rst_n = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
